// File: rtl/sccb_pkg.sv
// Shared types and constants for the SCCB 3-phase write master.
// Quarter-phase indices name the four ticks that make up one bus bit slot.
package sccb_pkg;

   typedef enum logic [4:0] {
      ST_IDLE  = 5'b00001,
      ST_START = 5'b00010,
      ST_BIT   = 5'b00100,
      ST_XBIT  = 5'b01000,
      ST_STOP  = 5'b10000
   } sccb_state_t;

   localparam logic [1:0] Q0 = 2'd0;
   localparam logic [1:0] Q1 = 2'd1;
   localparam logic [1:0] Q2 = 2'd2;
   localparam logic [1:0] Q3 = 2'd3;

   localparam logic [1:0] LAST_BYTE = 2'd2;

   function automatic int calc_qtr(input int clk_hz, input int scl_hz);
      return clk_hz / (4 * scl_hz);
   endfunction

endpackage

// File: rtl/sccb_tick_gen.sv
// Quarter-period divider: one-clk tick every QTR clocks while enabled,
// plus a 2-bit index of the quarter that the next tick will close.
module sccb_tick_gen #(
   parameter int QTR = 62
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic       clr,
   output logic       tick,
   output logic [1:0] quarter
);

   localparam int CW = (QTR > 1) ? $clog2(QTR) : 1;

   logic [CW-1:0] r_cnt;
   logic [1:0]    r_qtr;
   logic          w_wrap;

   assign w_wrap  = (r_cnt == CW'(QTR - 1));
   assign tick    = en & w_wrap;
   assign quarter = r_qtr;

   always_ff @(posedge clk) begin
      if (!rst_n || clr) begin
         r_cnt <= '0;
         r_qtr <= 2'd0;
      end else if (en) begin
         if (w_wrap) begin
            r_cnt <= '0;
            r_qtr <= r_qtr + 2'd1;
         end else begin
            r_cnt <= r_cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/sccb_master_wr.sv
// SCCB 3-phase write master: start, ID+X, sub-address+X, data+X, stop.
// All bus outputs are registered; every bus event lands on a quarter tick.
module sccb_master_wr
   import sccb_pkg::*;
#(
   parameter int CLK_FREQUENCE = 50_000_000,
   parameter int SCL_CLOCK     = 200_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       sccb_start,
   input  logic [7:0] devaddr,
   input  logic [7:0] regaddr,
   input  logic [7:0] wrdata,
   output logic       sccb_done,
   output logic       nack,
   output logic       sio_c,
   output logic       sio_d_o,
   output logic       sio_d_oe,
   input  logic       sio_d_i
);

   localparam int QTR = calc_qtr(CLK_FREQUENCE, SCL_CLOCK);

   sccb_state_t r_state, w_state_next;
   logic [1:0]  r_byte, w_byte_next;
   logic [2:0]  r_bit, w_bit_next;
   logic [7:0]  r_shift, w_shift_next;
   logic [7:0]  r_dev, r_reg, r_wr;
   logic [7:0]  w_load_byte;
   logic        r_sio_c, w_sio_c_next;
   logic        r_sio_d_o, w_sio_d_o_next;
   logic        r_sio_d_oe, w_sio_d_oe_next;
   logic        r_done, w_done_next;
   logic        r_nack, w_nack_next;
   logic        w_tick;
   logic [1:0]  w_quarter;
   logic        w_idle;
   logic        w_accept;

   assign w_idle   = (r_state == ST_IDLE);
   assign w_accept = w_idle & sccb_start;

   sccb_tick_gen #(
      .QTR (QTR)
   ) u_tick_gen (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (~w_idle),
      .clr     (w_idle),
      .tick    (w_tick),
      .quarter (w_quarter)
   );

   // Payload is frozen at the handshake so upstream may change it freely while busy.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_dev <= devaddr;
         r_reg <= regaddr;
         r_wr  <= wrdata;
      end
   end

   assign w_load_byte = (r_byte == 2'd0) ? r_reg : r_wr;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_byte     <= 2'd0;
         r_bit      <= 3'd7;
         r_shift    <= 8'd0;
         r_sio_c    <= 1'b1;
         r_sio_d_o  <= 1'b1;
         r_sio_d_oe <= 1'b1;
         r_done     <= 1'b1;
         r_nack     <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_byte     <= w_byte_next;
         r_bit      <= w_bit_next;
         r_shift    <= w_shift_next;
         r_sio_c    <= w_sio_c_next;
         r_sio_d_o  <= w_sio_d_o_next;
         r_sio_d_oe <= w_sio_d_oe_next;
         r_done     <= w_done_next;
         r_nack     <= w_nack_next;
      end
   end

   // Quarter labels below name the quarter being closed by the tick,
   // so each branch sets up the bus for the quarter that follows.
   always_comb begin
      w_state_next    = r_state;
      w_byte_next     = r_byte;
      w_bit_next      = r_bit;
      w_shift_next    = r_shift;
      w_sio_c_next    = r_sio_c;
      w_sio_d_o_next  = r_sio_d_o;
      w_sio_d_oe_next = r_sio_d_oe;
      w_done_next     = r_done;
      w_nack_next     = r_nack;

      case (r_state)
         ST_IDLE: begin
            if (sccb_start) begin
               w_state_next    = ST_START;
               w_done_next     = 1'b0;
               w_nack_next     = 1'b0;
               w_sio_c_next    = 1'b1;
               w_sio_d_o_next  = 1'b1;
               w_sio_d_oe_next = 1'b1;
            end
         end

         ST_START, ST_BIT, ST_XBIT, ST_STOP: begin
            if (w_tick) begin
               case (w_quarter)
                  Q0: begin
                     w_sio_c_next = 1'b1;
                     if (r_state == ST_START)
                        w_sio_d_o_next = 1'b0;
                  end
                  Q1: begin
                     if (r_state == ST_XBIT && sio_d_i)
                        w_nack_next = 1'b1;
                     if (r_state == ST_STOP)
                        w_sio_d_o_next = 1'b1;
                  end
                  Q2: begin
                     if (r_state != ST_STOP)
                        w_sio_c_next = 1'b0;
                  end
                  Q3: begin
                     case (r_state)
                        ST_START: begin
                           w_state_next    = ST_BIT;
                           w_byte_next     = 2'd0;
                           w_bit_next      = 3'd7;
                           w_shift_next    = r_dev;
                           w_sio_d_oe_next = 1'b1;
                           w_sio_d_o_next  = r_dev[7];
                        end
                        ST_BIT: begin
                           if (r_bit == 3'd0) begin
                              w_state_next    = ST_XBIT;
                              w_sio_d_oe_next = 1'b0;
                              w_sio_d_o_next  = 1'b1;
                           end else begin
                              w_bit_next     = r_bit - 3'd1;
                              w_shift_next   = {r_shift[6:0], r_shift[7]};
                              w_sio_d_o_next = r_shift[6];
                           end
                        end
                        ST_XBIT: begin
                           w_sio_d_oe_next = 1'b1;
                           if (r_byte == LAST_BYTE) begin
                              w_state_next   = ST_STOP;
                              w_sio_d_o_next = 1'b0;
                           end else begin
                              w_state_next   = ST_BIT;
                              w_byte_next    = r_byte + 2'd1;
                              w_bit_next     = 3'd7;
                              w_shift_next   = w_load_byte;
                              w_sio_d_o_next = w_load_byte[7];
                           end
                        end
                        ST_STOP: begin
                           w_state_next = ST_IDLE;
                           w_done_next  = 1'b1;
                        end
                        default: w_state_next = ST_IDLE;
                     endcase
                  end
               endcase
            end
         end

         default: begin
            w_state_next    = ST_IDLE;
            w_done_next     = 1'b1;
            w_sio_c_next    = 1'b1;
            w_sio_d_o_next  = 1'b1;
            w_sio_d_oe_next = 1'b1;
         end
      endcase
   end

   assign sccb_done = r_done;
   assign nack      = r_nack;
   assign sio_c     = r_sio_c;
   assign sio_d_o   = r_sio_d_o;
   assign sio_d_oe  = r_sio_d_oe;

endmodule

// File: tb/tb_sccb_master_wr.sv
// Bench for sccb_master_wr: a bus monitor decodes start/bits/stop from the pins,
// a device model drives the X slots, and each write is checked against its triple.
module tb_sccb_master_wr;

   localparam int CLK_HZ   = 50_000_000;
   localparam int SCL_HZ   = 200_000;
   localparam int QTR      = CLK_HZ / (4 * SCL_HZ);
   localparam int TXN_CLKS = 116 * QTR;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       sccb_start = 1'b0;
   logic [7:0] devaddr = 8'h00;
   logic [7:0] regaddr = 8'h00;
   logic [7:0] wrdata = 8'h00;
   logic       sio_d_i = 1'b0;
   logic       sccb_done, nack, sio_c, sio_d_o, sio_d_oe;

   sccb_master_wr #(
      .CLK_FREQUENCE (CLK_HZ),
      .SCL_CLOCK     (SCL_HZ)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .sccb_start (sccb_start),
      .devaddr    (devaddr),
      .regaddr    (regaddr),
      .wrdata     (wrdata),
      .sccb_done  (sccb_done),
      .nack       (nack),
      .sio_c      (sio_c),
      .sio_d_o    (sio_d_o),
      .sio_d_oe   (sio_d_oe),
      .sio_d_i    (sio_d_i)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // Monitor state
   int          cyc = 0;
   logic [1:0]  bits[$];
   logic [23:0] fr_bytes[$];
   bit          fr_xok[$];
   int          starts = 0, bad_glitch = 0, bad_timing = 0;
   int          done_falls = 0, done_rises = 0, low_cnt = 0, last_low = 0;
   int          last_rise = 0, xidx = 0, nack_slot = 3;
   logic        prev_c = 1'b1, prev_d = 1'b1, prev_done = 1'b1, prev_oe = 1'b1, prev_rst = 1'b0;
   logic [23:0] mon_by;
   bit          mon_ok;

   always @(negedge clk) begin
      cyc++;
      if (!sccb_done) low_cnt++;
      if (prev_done && !sccb_done) begin
         done_falls++;
         xidx = 0;
      end
      if (!prev_done && sccb_done) begin
         done_rises++;
         last_low = low_cnt;
         low_cnt = 0;
      end
      if (prev_oe && !sio_d_oe) xidx++;
      sio_d_i = !sio_d_oe && ((xidx - 1) == nack_slot);

      if (!rst_n || !prev_rst) begin
         bits.delete();
      end else if (!prev_c && sio_c) begin
         if (bits.size() > 0 && (cyc - last_rise) != 4 * QTR) bad_timing++;
         last_rise = cyc;
         if (bits.size() < 27) bits.push_back({sio_d_oe, sio_d_o});
      end else if (prev_c && !sio_c) begin
         if (bits.size() > 0 && (cyc - last_rise) != 2 * QTR) bad_timing++;
      end else if (prev_c && sio_c && (sio_d_o !== prev_d)) begin
         if (!sio_d_o && bits.size() == 0) begin
            starts++;
         end else if (sio_d_o && bits.size() == 27) begin
            mon_ok = 1'b1;
            for (int b = 0; b < 3; b++) begin
               for (int i = 0; i < 8; i++) begin
                  mon_by[23 - 8 * b - i] = bits[b * 9 + i][0];
                  if (!bits[b * 9 + i][1]) mon_ok = 1'b0;
               end
               if (bits[b * 9 + 8][1]) mon_ok = 1'b0;
            end
            fr_bytes.push_back(mon_by);
            fr_xok.push_back(mon_ok);
            bits.delete();
         end else begin
            bad_glitch++;
         end
      end

      prev_c    = sio_c;
      prev_d    = sio_d_o;
      prev_done = sccb_done;
      prev_oe   = sio_d_oe;
      prev_rst  = rst_n;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   // One full write as the sequencer would issue it; slot 0..2 makes that X slot NA, 3 = all ack.
   task automatic do_write(input logic [7:0] d, input logic [7:0] r, input logic [7:0] w,
                           input int slot, input bit busy);
      int f0, r0, s0, nfr, t;
      f0 = done_falls;
      r0 = done_rises;
      s0 = starts;
      nfr = fr_bytes.size();
      nack_slot = slot;
      devaddr = d;
      regaddr = r;
      wrdata = w;
      sccb_start = 1'b1;
      t = 0;
      while (done_falls == f0 && t < 8) begin
         step();
         t++;
      end
      sccb_start = 1'b0;
      devaddr = 8'($urandom);
      regaddr = 8'($urandom);
      wrdata = 8'($urandom);
      check("done_fall", 32'(done_falls - f0), 32'd1);
      check("nack_clear_on_start", 32'(nack), 32'd0);
      if (busy) begin
         t = 0;
         while (bits.size() < 12 && t < 4000) begin
            step();
            t++;
         end
         devaddr = 8'hAA;
         regaddr = 8'h55;
         wrdata = 8'h01;
         sccb_start = 1'b1;
         repeat (3) step();
         sccb_start = 1'b0;
      end
      t = 0;
      while (done_rises == r0 && t < TXN_CLKS + 100) begin
         step();
         t++;
      end
      check("done_rise", 32'(done_rises - r0), 32'd1);
      check("done_low_len_ok", 32'(last_low >= TXN_CLKS - 1 && last_low <= TXN_CLKS + 1), 32'd1);
      check("start_cond", 32'(starts - s0), 32'd1);
      check("frame_count", 32'(fr_bytes.size() - nfr), 32'd1);
      if (fr_bytes.size() > nfr) begin
         check("frame_bytes", 32'(fr_bytes[nfr]), {8'h00, d, r, w});
         check("xslots_released", 32'(fr_xok[nfr]), 32'd1);
      end
      check("nack", 32'(nack), 32'(slot < 3));
      repeat (4) step();
      check("single_txn", 32'(done_falls - f0), 32'd1);
      check("idle_done", 32'(sccb_done), 32'd1);
      $display("write %02h %02h %02h slot=%0d busy=%0d low=%0d nack=%0b", d, r, w, slot, busy, last_low, nack);
   endtask

   initial begin
      int t, f0;
      rst_n = 1'b0;
      repeat (3) step();
      check("rst_done", 32'(sccb_done), 32'd1);
      check("rst_nack", 32'(nack), 32'd0);
      check("rst_sio_c", 32'(sio_c), 32'd1);
      check("rst_sio_d_o", 32'(sio_d_o), 32'd1);
      check("rst_sio_d_oe", 32'(sio_d_oe), 32'd1);
      rst_n = 1'b1;
      repeat (2) step();

      do_write(8'h60, 8'h12, 8'h80, 3, 1'b0);
      do_write(8'h60, 8'h12, 8'h80, 3, 1'b1);
      do_write(8'h42, 8'h0F, 8'hC3, 1, 1'b0);

      // Abort during byte 2; nack from the previous write must also clear on this start
      f0 = done_falls;
      nack_slot = 3;
      devaddr = 8'h60;
      regaddr = 8'h3A;
      wrdata = 8'h5C;
      sccb_start = 1'b1;
      t = 0;
      while (done_falls == f0 && t < 8) begin
         step();
         t++;
      end
      sccb_start = 1'b0;
      check("abort_done_fall", 32'(done_falls - f0), 32'd1);
      check("abort_nack_clear", 32'(nack), 32'd0);
      t = 0;
      while (bits.size() < 20 && t < 6000) begin
         step();
         t++;
      end
      check("abort_reached_byte2", 32'(bits.size() >= 20), 32'd1);
      rst_n = 1'b0;
      step();
      check("abort_done", 32'(sccb_done), 32'd1);
      check("abort_sio_c", 32'(sio_c), 32'd1);
      check("abort_sio_d_oe", 32'(sio_d_oe), 32'd1);
      check("abort_sio_d_o", 32'(sio_d_o), 32'd1);
      rst_n = 1'b1;
      repeat (20) step();
      check("abort_stays_idle", 32'(sccb_done), 32'd1);
      $display("abort during byte 2: done=%0b sio_c=%0b", sccb_done, sio_c);

      do_write(8'h60, 8'h3A, 8'h5C, 3, 1'b0);

      for (int k = 0; k < 3; k++) begin
         do_write(8'($urandom), 8'($urandom), 8'($urandom), int'($urandom_range(0, 3)), 1'b0);
      end

      check("no_sda_change_while_scl_high", 32'(bad_glitch), 32'd0);
      check("scl_period_duty", 32'(bad_timing), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
